// File: rtl/writeback_stage_pkg.sv
// Pipeline stage register types shared by the execute and writeback stages.
// Holds the EX_WB register layout and register-file addressing constants.
package pipeline_stage_registers;

  localparam int unsigned PIPE_XLEN  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [PIPE_XLEN-1:0]  alu_result;
    logic                  alu_result_ready;
    logic                  do_not_execute;
    logic [REG_ADDR_W-1:0] reg_wr_addr;
    logic                  reg_wr_en;
  } EX_WB;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback stage register, decode read ports and EX forwarding bundle.
import pipeline_stage_registers::*;

interface writeback_stage_if #(
  parameter int unsigned XLEN = 32
);
  EX_WB                  ex_wb_r;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]       fwd_data;

  modport master (
    output ex_wb_r, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  ex_wb_r, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/writeback_stage_regfile_2r1w.sv
// Integer register file: one synchronous write port, two write-first bypassed
// read ports and one raw debug read port. x0 is never written so it reads zero.
import pipeline_stage_registers::*;

module regfile_2r1w #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Write-first: a same-cycle write to the named register wins over the array.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != REG_ZERO) begin
      rs1_data = (wr_en && (rs1_addr == wr_addr)) ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != REG_ZERO) begin
      rs2_data = (wr_en && (rs2_addr == wr_addr)) ? wr_data : regs[rs2_addr];
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits EX_WB results to the register file, publishes the
// last committed write for forwarding and counts retired instructions.
import pipeline_stage_registers::*;

module writeback_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  writeback_stage_if.slave          wb,
  output logic [INSTRET_WIDTH-1:0]  instret,
  input  logic [REG_ADDR_W-1:0]     dbg_addr,
  output logic [XLEN-1:0]           dbg_data
);

  logic            retire;
  logic            commit;
  logic [XLEN-1:0] wr_data;

  assign retire  = wb.ex_wb_r.alu_result_ready & ~wb.ex_wb_r.do_not_execute;
  assign commit  = retire & wb.ex_wb_r.reg_wr_en & (wb.ex_wb_r.reg_wr_addr != REG_ZERO);
  assign wr_data = XLEN'(wb.ex_wb_r.alu_result);

  regfile_2r1w #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (commit),
    .wr_addr  (wb.ex_wb_r.reg_wr_addr),
    .wr_data  (wr_data),
    .rs1_addr (wb.rs1_addr),
    .rs2_addr (wb.rs2_addr),
    .rs1_data (wb.rs1_data),
    .rs2_data (wb.rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Address/data hold their last committed value; only the valid flag tracks every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.fwd_valid <= 1'b0;
      wb.fwd_addr  <= '0;
      wb.fwd_data  <= '0;
    end else begin
      wb.fwd_valid <= commit;
      if (commit) begin
        wb.fwd_addr <= wb.ex_wb_r.reg_wr_addr;
        wb.fwd_data <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + INSTRET_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage, plus a narrow-counter
// instance to exercise instret wrap-around.
import pipeline_stage_registers::*;

module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  writeback_stage_if #(.XLEN(32)) wb ();
  logic [63:0] instret;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  writeback_stage #(
    .XLEN          (32),
    .NUM_REGS      (32),
    .INSTRET_WIDTH (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb),
    .instret  (instret),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  writeback_stage_if #(.XLEN(32)) wb4 ();
  logic [3:0]  instret4;
  logic [4:0]  dbg_addr4;
  logic [31:0] dbg_data4;

  writeback_stage #(
    .XLEN          (32),
    .NUM_REGS      (32),
    .INSTRET_WIDTH (4)
  ) dut4 (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb4),
    .instret  (instret4),
    .dbg_addr (dbg_addr4),
    .dbg_data (dbg_data4)
  );

  task automatic drive(input logic rdy, input logic dne, input logic wen,
                       input logic [4:0] addr, input logic [31:0] res);
    wb.ex_wb_r.alu_result_ready = rdy;
    wb.ex_wb_r.do_not_execute   = dne;
    wb.ex_wb_r.reg_wr_en        = wen;
    wb.ex_wb_r.reg_wr_addr      = addr;
    wb.ex_wb_r.alu_result       = res;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    wb.rs1_addr = 5'd5; wb.rs2_addr = 5'd9; dbg_addr = 5'd3;
    wb4.ex_wb_r = '0; wb4.rs1_addr = '0; wb4.rs2_addr = '0; dbg_addr4 = '0;
    #3;
    checks++;
    if (instret !== 64'd0 || wb.fwd_valid !== 1'b0 || wb.rs1_data !== 32'd0 ||
        wb.rs2_data !== 32'd0 || dbg_data !== 32'd0 || instret4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: instret=%0d fwd_valid=%b rs1=%h rs2=%h dbg=%h instret4=%0d required all 0",
               instret, wb.fwd_valid, wb.rs1_data, wb.rs2_data, dbg_data, instret4);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_commit();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h12345678);
    wb.rs1_addr = 5'd5;
    #1;
    checks++;
    if (wb.rs1_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_bypass: got %h required 12345678", wb.rs1_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (wb.rs1_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_array: got %h required 12345678", wb.rs1_data);
    end
    checks++;
    if (wb.fwd_valid !== 1'b1 || wb.fwd_addr !== 5'd5 || wb.fwd_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_fwd: got v=%b a=%0d d=%h required v=1 a=5 d=12345678",
               wb.fwd_valid, wb.fwd_addr, wb.fwd_data);
    end
    checks++;
    if (instret !== 64'd1) begin
      errors++;
      $display("FAIL basic_instret: got %0d required 1", instret);
    end
  endtask

  task automatic test_x0_write();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    wb.rs1_addr = 5'd0; wb.rs2_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    checks++;
    if (wb.rs1_data !== 32'd0 || wb.rs2_data !== 32'd0 || dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL x0_read_same_cycle: rs1=%h rs2=%h dbg=%h required 0", wb.rs1_data, wb.rs2_data, dbg_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (wb.fwd_valid !== 1'b0 || instret !== 64'd2 || dbg_data !== 32'd0 || wb.fwd_addr !== 5'd5) begin
      errors++;
      $display("FAIL x0_after: fwd_valid=%b instret=%0d dbg=%h fwd_addr=%0d required 0,2,0,5",
               wb.fwd_valid, instret, dbg_data, wb.fwd_addr);
    end
  endtask

  task automatic test_squash();
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h11111111);
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
    wb.rs1_addr = 5'd7;
    #1;
    checks++;
    if (wb.rs1_data !== 32'h11111111) begin
      errors++;
      $display("FAIL squash_no_bypass: got %h required 11111111", wb.rs1_data);
    end
    step();
    idle();
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (dbg_data !== 32'h11111111 || instret !== 64'd3 || wb.fwd_valid !== 1'b0 ||
        wb.fwd_addr !== 5'd7 || wb.fwd_data !== 32'h11111111) begin
      errors++;
      $display("FAIL squash_after: x7=%h instret=%0d fv=%b fa=%0d fd=%h required 11111111,3,0,7,11111111",
               dbg_data, instret, wb.fwd_valid, wb.fwd_addr, wb.fwd_data);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h99999999);
    wb.rs2_addr = 5'd9;
    #1;
    checks++;
    if (wb.rs2_data !== 32'd0) begin
      errors++;
      $display("FAIL bubble_no_bypass: got %h required 0", wb.rs2_data);
    end
    step();
    idle();
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data !== 32'd0 || instret !== 64'd3 || wb.fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bubble_after: x9=%h instret=%0d fv=%b required 0,3,0", dbg_data, instret, wb.fwd_valid);
    end
  endtask

  task automatic test_back_to_back();
    wb.rs1_addr = 5'd3; wb.rs2_addr = 5'd3; dbg_addr = 5'd3;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd1);
    #1;
    checks++;
    if (wb.rs1_data !== 32'd1 || wb.rs2_data !== 32'd1) begin
      errors++;
      $display("FAIL b2b_first: rs1=%h rs2=%h required 1", wb.rs1_data, wb.rs2_data);
    end
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd2);
    #1;
    checks++;
    if (wb.rs1_data !== 32'd2 || wb.rs2_data !== 32'd2 || dbg_data !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second: rs1=%h rs2=%h dbg=%h required 2,2,1", wb.rs1_data, wb.rs2_data, dbg_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (dbg_data !== 32'd2 || instret !== 64'd5 || wb.fwd_data !== 32'd2 || wb.fwd_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after: x3=%h instret=%0d fd=%h fv=%b required 2,5,2,1",
               dbg_data, instret, wb.fwd_data, wb.fwd_valid);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b1, 5'(i), 32'h01010101 * 32'(i));
      step();
    end
    idle();
    dbg_addr = 5'd31; wb.rs1_addr = 5'd17; wb.rs2_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'h1F1F1F1F || wb.rs1_data !== 32'h11111111 || wb.rs2_data !== 32'h01010101 ||
        instret !== 64'd36) begin
      errors++;
      $display("FAIL fill: x31=%h x17=%h x1=%h instret=%0d required 1f1f1f1f,11111111,01010101,36",
               dbg_data, wb.rs1_data, wb.rs2_data, instret);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dbg_data !== 32'd0 || wb.rs1_data !== 32'd0 || wb.rs2_data !== 32'd0 || instret !== 64'd0 ||
        wb.fwd_valid !== 1'b0 || wb.fwd_addr !== 5'd0 || wb.fwd_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: dbg=%h rs1=%h rs2=%h instret=%0d fv=%b fa=%0d fd=%h required all 0",
               dbg_data, wb.rs1_data, wb.rs2_data, instret, wb.fwd_valid, wb.fwd_addr, wb.fwd_data);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b0;
    step();
    idle();
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 32'hA5A5A5A5 || instret !== 64'd1 || wb.fwd_valid !== 1'b1 || wb.fwd_addr !== 5'd4) begin
      errors++;
      $display("FAIL release_commit: x4=%h instret=%0d fv=%b fa=%0d required a5a5a5a5,1,1,4",
               dbg_data, instret, wb.fwd_valid, wb.fwd_addr);
    end
  endtask

  task automatic test_wrap();
    wb4.ex_wb_r.alu_result_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    wb4.ex_wb_r.alu_result_ready = 1'b0;
    #1;
    checks++;
    if (instret4 !== 4'd15) begin
      errors++;
      $display("FAIL wrap_preload: got %0d required 15", instret4);
    end
    wb4.ex_wb_r.alu_result_ready = 1'b1;
    step();
    wb4.ex_wb_r.alu_result_ready = 1'b0;
    #1;
    checks++;
    if (instret4 !== 4'd0) begin
      errors++;
      $display("FAIL wrap: got %0d required 0", instret4);
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_x0_write();
    test_squash();
    test_bubble();
    test_back_to_back();
    test_reset_midrun();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
